// File: rtl/fft_pkg.sv
// Shared constants for the CORDIC FFT datapath: sample width, binary-angle
// constants, the arctangent table and the butterfly FSM encoding.
package fft_pkg;

    localparam int FFT_W = 17;

    localparam logic [31:0] ANG_PI      = 32'h8000_0000;
    localparam logic [31:0] ANG_HALF_PI = 32'h4000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ROT  = 2'd2,
        ST_DONE = 2'd3
    } fsm_state_e;

    // atan(2^-i) as a binary angle (2^31 = pi), rounded to nearest
    function automatic logic [31:0] atan_lookup(input logic [4:0] idx);
        logic [31:0] a;
        case (idx)
            5'd0:  a = 32'h2000_0000;
            5'd1:  a = 32'h12E4_051E;
            5'd2:  a = 32'h09FB_385B;
            5'd3:  a = 32'h0511_11D4;
            5'd4:  a = 32'h028B_0D43;
            5'd5:  a = 32'h0145_D7E1;
            5'd6:  a = 32'h00A2_F61E;
            5'd7:  a = 32'h0051_7C55;
            5'd8:  a = 32'h0028_BE53;
            5'd9:  a = 32'h0014_5F2F;
            5'd10: a = 32'h000A_2F98;
            5'd11: a = 32'h0005_17CC;
            5'd12: a = 32'h0002_8BE6;
            5'd13: a = 32'h0001_45F3;
            5'd14: a = 32'h0000_A2FA;
            5'd15: a = 32'h0000_517D;
            5'd16: a = 32'h0000_28BE;
            5'd17: a = 32'h0000_145F;
            5'd18: a = 32'h0000_0A30;
            5'd19: a = 32'h0000_0518;
            5'd20: a = 32'h0000_028C;
            5'd21: a = 32'h0000_0146;
            5'd22: a = 32'h0000_00A3;
            5'd23: a = 32'h0000_0051;
            5'd24: a = 32'h0000_0029;
            5'd25: a = 32'h0000_0014;
            5'd26: a = 32'h0000_000A;
            5'd27: a = 32'h0000_0005;
            5'd28: a = 32'h0000_0003;
            5'd29: a = 32'h0000_0001;
            5'd30: a = 32'h0000_0001;
            default: a = 32'h0000_0000;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_iter_rot.sv
// One combinational CORDIC rotation-mode micro-step: drives z toward zero,
// rotating (x,y) by +/-atan(2^-i).
module cordic_iter_rot
    import fft_pkg::*;
#(
    parameter int XW = 21,
    parameter int IW = 4
) (
    input  logic signed [XW-1:0] x_in,
    input  logic signed [XW-1:0] y_in,
    input  logic signed [31:0]   z_in,
    input  logic        [IW-1:0] iter,
    output logic signed [XW-1:0] x_out,
    output logic signed [XW-1:0] y_out,
    output logic signed [31:0]   z_out
);

    logic signed [XW-1:0] sh_x;
    logic signed [XW-1:0] sh_y;
    logic signed [31:0]   ang;

    always_comb begin
        sh_x = x_in >>> iter;
        sh_y = y_in >>> iter;
        ang  = signed'(atan_lookup(5'(iter)));
        if (!z_in[31]) begin
            x_out = x_in - sh_y;
            y_out = y_in + sh_x;
            z_out = z_in - ang;
        end else begin
            x_out = x_in + sh_y;
            y_out = y_in - sh_x;
            z_out = z_in + ang;
        end
    end

endmodule

// File: rtl/inv_butterfly2_seq.sv
// Inverse radix-2 butterfly: A = (S+D)/2, B = rot(-zangle)((S-D)/2), with B
// produced by an iterative one-step-per-clock CORDIC behind valid/ready.
module inv_butterfly2_seq
    import fft_pkg::*;
#(
    parameter int W     = FFT_W,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] xs,
    input  logic signed [W-1:0] ys,
    input  logic signed [W-1:0] xd,
    input  logic signed [W-1:0] yd,
    input  logic        [31:0]  zangle,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] xa,
    output logic signed [W-1:0] ya,
    output logic signed [W-1:0] xb,
    output logic signed [W-1:0] yb
);

    // Headroom: |t| up to 2^(W-1)*sqrt(2) plus residual gain, then GUARD bits
    localparam int XW = W + 2 + GUARD;
    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW = XW + 6;
    localparam logic [IW-1:0] LAST = IW'(ITER - 1);
    localparam logic signed [XW:0] SAT_HI = (XW+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [XW:0] SAT_LO = -SAT_HI - (XW+1)'(1);

    function automatic logic signed [W-1:0] half_sum(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b,
        input logic                sub
    );
        logic signed [W:0] s;
        s = sub ? ((W+1)'(a) - (W+1)'(b)) : ((W+1)'(a) + (W+1)'(b));
        return W'(s >>> 1);
    endfunction

    // 1/K ~ 1/2+1/16+1/32+1/64, evaluated exactly then rounded once so small
    // negative inputs do not pick up a floor bias from each shifted term
    function automatic logic signed [XW-1:0] prescale(input logic signed [W-1:0] t);
        logic signed [PW-1:0] te;
        logic signed [PW-1:0] pe;
        te = PW'(t) <<< (GUARD + 6);
        pe = (te >>> 1) + (te >>> 4) + (te >>> 5) + (te >>> 6) + PW'(32);
        return XW'(pe >>> 6);
    endfunction

    function automatic logic signed [W-1:0] rnd_sat(input logic signed [XW-1:0] v);
        logic signed [XW:0] r;
        logic signed [W-1:0] res;
        r = ((XW+1)'(v) + (XW+1)'(2 ** (GUARD - 1))) >>> GUARD;
        if (r > SAT_HI)      res = SAT_HI[W-1:0];
        else if (r < SAT_LO) res = SAT_LO[W-1:0];
        else                 res = W'(r);
        return res;
    endfunction

    fsm_state_e           state_q, state_d;
    logic        [IW-1:0] cnt_q, cnt_d;
    logic signed [W-1:0]  sx_q, sx_d, sy_q, sy_d, dx_q, dx_d, dy_q, dy_d;
    logic        [31:0]   zin_q, zin_d;
    logic signed [W-1:0]  ax_q, ax_d, ay_q, ay_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [31:0]   z_q, z_d;
    logic signed [W-1:0]  xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;

    logic signed [W-1:0]  tx, ty;
    logic signed [XW-1:0] px, py;
    logic        [31:0]   phi;
    logic                 fold_pos, fold_neg;
    logic signed [XW-1:0] x_nx, y_nx;
    logic signed [31:0]   z_nx;

    assign tx  = half_sum(sx_q, dx_q, 1'b1);
    assign ty  = half_sum(sy_q, dy_q, 1'b1);
    assign px  = prescale(tx);
    assign py  = prescale(ty);
    assign phi = 32'd0 - zin_q;

    // -pi negates to itself and is folded as +pi
    assign fold_pos = (phi == ANG_PI) || (!phi[31] && (phi > ANG_HALF_PI));
    assign fold_neg = phi[31] && (phi != ANG_PI) && (phi < (32'd0 - ANG_HALF_PI));

    cordic_iter_rot #(.XW(XW), .IW(IW)) u_rot (
        .x_in  (x_q),
        .y_in  (y_q),
        .z_in  (z_q),
        .iter  (cnt_q),
        .x_out (x_nx),
        .y_out (y_nx),
        .z_out (z_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        zin_d   = zin_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sx_d    = xs;
                    sy_d    = ys;
                    dx_d    = xd;
                    dy_d    = yd;
                    zin_d   = zangle;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                ax_d = half_sum(sx_q, dx_q, 1'b0);
                ay_d = half_sum(sy_q, dy_q, 1'b0);
                if (fold_pos) begin
                    x_d = -py;
                    y_d = px;
                    z_d = signed'(phi - ANG_HALF_PI);
                end else if (fold_neg) begin
                    x_d = py;
                    y_d = -px;
                    z_d = signed'(phi + ANG_HALF_PI);
                end else begin
                    x_d = px;
                    y_d = py;
                    z_d = signed'(phi);
                end
                cnt_d   = '0;
                state_d = ST_ROT;
            end
            ST_ROT: begin
                x_d = x_nx;
                y_d = y_nx;
                z_d = z_nx;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    xa_d    = ax_q;
                    ya_d    = ay_q;
                    xb_d    = rnd_sat(x_nx);
                    yb_d    = rnd_sat(y_nx);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            zin_q   <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xa_q    <= '0;
            ya_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            zin_q   <= zin_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign xa        = xa_q;
    assign ya        = ya_q;
    assign xb        = xb_q;
    assign yb        = yb_q;

endmodule

// File: tb/tb_inv_butterfly2_seq.sv
// Randomized and directed checks of inv_butterfly2_seq against a real-valued
// model of the inverse butterfly, including a round trip through a forward model.
module tb_inv_butterfly2_seq;

    localparam int  W     = 17;
    localparam int  ITER  = 16;
    localparam int  GUARD = 2;
    localparam real PI    = 3.14159265358979323846;
    localparam int  BMAX  = (2 ** (W - 1)) - 1;
    localparam int  BMIN  = -(2 ** (W - 1));

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    logic signed [W-1:0] xs = '0, ys = '0, xd = '0, yd = '0;
    logic signed [W-1:0] xa, ya, xb, yb;
    logic [31:0] zangle = '0;

    int  n_chk = 0;
    int  n_pass = 0;
    real gain;

    always #5 clock = ~clock;

    inv_butterfly2_seq #(.W(W), .ITER(ITER), .GUARD(GUARD)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .xs        (xs),
        .ys        (ys),
        .xd        (xd),
        .yd        (yd),
        .zangle    (zangle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xa        (xa),
        .ya        (ya),
        .xb        (xb),
        .yb        (yb)
    );

    task automatic check(input string tag, input int obs, input int exp_v, input int tol);
        n_chk++;
        if (obs >= exp_v - tol && obs <= exp_v + tol) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (+-%0d)", tag, obs, exp_v, tol);
    endtask

    function automatic int rnd_clamp(input real v);
        int r;
        r = $rtoi($floor(v + 0.5));
        if (r > BMAX) r = BMAX;
        if (r < BMIN) r = BMIN;
        return r;
    endfunction

    // B carries the residual gain of the shift-add 1/K against the true CORDIC K
    task automatic model(input int sx, sy, dx, dy, input logic [31:0] z,
                         output int eax, eay, ebx, eby);
        real phi, tx, ty;
        phi = -($itor($signed(z)) * PI / 2147483648.0);
        tx  = (sx - dx) / 2.0;
        ty  = (sy - dy) / 2.0;
        eax = $rtoi($floor((sx + dx) / 2.0));
        eay = $rtoi($floor((sy + dy) / 2.0));
        ebx = rnd_clamp(gain * (tx * $cos(phi) - ty * $sin(phi)));
        eby = rnd_clamp(gain * (tx * $sin(phi) + ty * $cos(phi)));
    endtask

    task automatic run_op(input int sx, sy, dx, dy, input logic [31:0] z, input bit junk,
                          output int oxa, oya, oxb, oyb, output int lat);
        int wn;
        wn = 0;
        while (!in_ready && wn < 50) begin
            @(posedge clock); #1; wn++;
        end
        xs = W'(sx); ys = W'(sy); xd = W'(dx); yd = W'(dy); zangle = z;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = junk;
        xs = W'($urandom); ys = W'($urandom); xd = W'($urandom); yd = W'($urandom);
        zangle = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
            if (lat >= 10) in_valid = 1'b0;
            else if (junk) xs = W'($urandom);
        end
        in_valid = 1'b0;
        oxa = int'(xa); oya = int'(ya); oxb = int'(xb); oyb = int'(yb);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        check({tag, "_vld_drop"}, int'(out_valid), 0, 0);
        check({tag, "_rdy_back"}, int'(in_ready), 1, 0);
    endtask

    task automatic do_case(input string tag, input int sx, sy, dx, dy, input logic [31:0] z,
                           input int tol_a, tol_b, input bit junk, output int oyb);
        int oxa, oya, oxb, lat, eax, eay, ebx, eby;
        model(sx, sy, dx, dy, z, eax, eay, ebx, eby);
        out_ready = 1'b1;
        run_op(sx, sy, dx, dy, z, junk, oxa, oya, oxb, oyb, lat);
        check({tag, "_lat"}, lat, ITER + 1, 0);
        check({tag, "_xa"}, oxa, eax, tol_a);
        check({tag, "_ya"}, oya, eay, tol_a);
        check({tag, "_xb"}, oxb, ebx, tol_b);
        check({tag, "_yb"}, oyb, eby, tol_b);
        finish_op(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int oyb, oxa, oya, oxb, lat, eax, eay, ebx, eby;
        gain = 1.0;
        for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));
        gain = gain * 39.0 / 64.0;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        check("rst_vld", int'(out_valid), 0, 0);
        check("rst_rdy", int'(in_ready), 1, 0);
        check("rst_xa", int'(xa), 0, 0);
        check("rst_ya", int'(ya), 0, 0);
        check("rst_xb", int'(xb), 0, 0);
        check("rst_yb", int'(yb), 0, 0);

        do_case("t1", 1000, 0, 200, 0, 32'h0, 0, 4, 1'b0, oyb);
        do_case("t1j", -1234, 5678, 4321, -876, 32'h1555_5555, 0, 4, 1'b1, oyb);
        do_case("t2", 500, 300, -300, 300, 32'hC000_0000, 0, 4, 1'b0, oyb);
        check("t2_sign", int'(oyb > 0), 1, 0);
        do_case("t3", -2, 0, -1, 0, 32'h0, 0, 1, 1'b0, oyb);
        do_case("tpi", 300, 100, -100, -100, 32'h8000_0000, 0, 4, 1'b0, oyb);
        do_case("tfn", 2000, -700, -1500, 900, 32'h6000_0000, 0, 4, 1'b0, oyb);
        do_case("tfp", -900, 2500, 1100, -400, 32'hA000_0000, 0, 4, 1'b0, oyb);
        do_case("tsh", 65535, 0, -65536, 0, 32'h0, 0, 4, 1'b0, oyb);
        do_case("tsl", -65536, 0, 65535, 0, 32'h0, 0, 4, 1'b0, oyb);

        // backpressure: hold DONE for 5 cycles with in_valid noise
        model(3000, -2000, 1000, 500, 32'h2000_0000, eax, eay, ebx, eby);
        out_ready = 1'b0;
        run_op(3000, -2000, 1000, 500, 32'h2000_0000, 1'b0, oxa, oya, oxb, oyb, lat);
        check("t4_lat", lat, ITER + 1, 0);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clock); #1;
            check("t4_hold_vld", int'(out_valid), 1, 0);
            check("t4_hold_rdy", int'(in_ready), 0, 0);
            check("t4_hold_xa", int'(xa), eax, 0);
            check("t4_hold_ya", int'(ya), eay, 0);
            check("t4_hold_xb", int'(xb), ebx, 4);
            check("t4_hold_yb", int'(yb), eby, 4);
        end
        in_valid = 1'b0;
        finish_op("t4");

        // reset mid-rotation
        out_ready = 1'b1;
        xs = 17'sd4000; ys = 17'sd100; xd = -17'sd800; yd = 17'sd50; zangle = 32'h1000_0000;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("t5_vld", int'(out_valid), 0, 0);
        check("t5_xa", int'(xa), 0, 0);
        check("t5_ya", int'(ya), 0, 0);
        check("t5_xb", int'(xb), 0, 0);
        check("t5_yb", int'(yb), 0, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        #1 check("t5_rdy", int'(in_ready), 1, 0);
        do_case("t5b", -700, 1200, 300, -200, 32'hE000_0000, 0, 4, 1'b0, oyb);

        // round trip through an ideal forward butterfly with 16-point twiddles
        for (int n = 0; n < 200; n++) begin
            int ax, ay, bx, by, k, rx, ry;
            logic [31:0] z;
            real zr;
            ax = int'($urandom_range(0, 32766)) - 16383;
            ay = int'($urandom_range(0, 32766)) - 16383;
            bx = int'($urandom_range(0, 32766)) - 16383;
            by = int'($urandom_range(0, 32766)) - 16383;
            k  = int'($urandom_range(0, 15));
            z  = 32'd0 - (32'(k) << 28);
            zr = -2.0 * PI * k / 16.0;
            rx = $rtoi($floor(bx * $cos(zr) - by * $sin(zr) + 0.5));
            ry = $rtoi($floor(bx * $sin(zr) + by * $cos(zr) + 0.5));
            out_ready = 1'($urandom_range(0, 1));
            run_op(ax + rx, ay + ry, ax - rx, ay - ry, z, 1'b0, oxa, oya, oxb, oyb, lat);
            check("rt_lat", lat, ITER + 1, 0);
            check("rt_xa", oxa, ax, 1);
            check("rt_ya", oya, ay, 1);
            check("rt_xb", oxb, rnd_clamp(gain * bx), 6);
            check("rt_yb", oyb, rnd_clamp(gain * by), 6);
            if (!out_ready) repeat ($urandom_range(0, 3)) @(posedge clock);
            #1 finish_op("rt");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
